instr_reader: RTL and testbench

- Read-side sequencer and checker for the instruction register. It pairs with the register's combinational read port.
- On a start command it walks read_pointer over a run of up to 32 consecutive slots, wrapping from 31 to 0. Each fetched instruction_word is presented on a valid/ready output stream.
- Each word's stored result is recomputed from its opcode and operands, and mismatches are flagged and counted. The block is the verification-side consumer of the instr_register_pkg types.

---
 rtl/instr_reader.sv | 125 ++++++++++++
 tb/tb_instr_reader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_reader.sv
// instr_reader: read-side sequencer and checker for the instruction register (optional checker: INSTR_READER_CHECK_EN)
package instr_register_pkg;
  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic [4:0] address_t;
  typedef struct packed {
    opcode_t opc;
    operand_t op_a;
    operand_t op_b;
    logic signed [63:0] result;
  } instruction_t;
endpackage

module instr_reader
  import instr_register_pkg::*;
#(
  parameter int MAX_COUNT = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  address_t     start_ptr,
  input  logic [5:0]   count,
  input  instruction_t instruction_word,
  output address_t     read_pointer,
  output logic         out_valid,
  input  logic         out_ready,
  output instruction_t out_instr,
  output address_t     out_index,
  output logic         mismatch,
  output logic         busy,
  output logic         done,
  output logic [5:0]   err_count
);
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;
  state_t r_state, w_next;
  address_t r_ptr;
  logic [5:0] r_rem;
  logic w_xfer, w_go;
  logic [5:0] w_len;
  assign w_xfer = out_valid & out_ready;
  assign w_go = (r_state == IDLE) & start;
  assign w_len = (count > 6'(MAX_COUNT)) ? 6'(MAX_COUNT) : count;
  assign read_pointer = r_ptr;
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (count != 6'd0) ? FETCH : DONE;
      FETCH:   w_next = PRESENT;
      PRESENT: if (w_xfer) w_next = (r_rem == 6'd1) ? DONE : FETCH;
      default: w_next = IDLE;
    endcase
  end
  // state-decoded outputs
  always_comb begin
    out_valid = (r_state == PRESENT);
    busy = (r_state != IDLE);
    done = (r_state == DONE);
  end
  // run pointer, remaining count and captured word
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_ptr <= '0;
      r_rem <= '0;
      out_instr <= '0;
      out_index <= '0;
    end else begin
      if (w_go && count != 6'd0) begin
        r_ptr <= start_ptr;
        r_rem <= w_len;
      end
      if (r_state == FETCH) begin
        out_instr <= instruction_word;
        out_index <= r_ptr;
      end
      if (w_xfer) begin
        r_ptr <= r_ptr + 5'd1;
        r_rem <= r_rem - 6'd1;
      end
    end
`ifdef INSTR_READER_CHECK_EN
  logic signed [63:0] w_a, w_b, w_d, w_exp;
  logic w_skip, w_mis, r_mis;
  logic [5:0] r_err;
  // recompute the expected result with 64-bit sign-extended operands
  always_comb begin
    w_a = {{32{instruction_word.op_a[31]}}, instruction_word.op_a};
    w_b = {{32{instruction_word.op_b[31]}}, instruction_word.op_b};
    w_skip = (instruction_word.opc == DIV || instruction_word.opc == MOD) && w_b == 64'sd0;
    w_d = w_skip ? 64'sd1 : w_b;
    case (instruction_word.opc)
      PASSA:   w_exp = w_a;
      PASSB:   w_exp = w_b;
      ADD:     w_exp = w_a + w_b;
      SUB:     w_exp = w_a - w_b;
      MULT:    w_exp = w_a * w_b;
      DIV:     w_exp = w_a / w_d;
      MOD:     w_exp = w_a % w_d;
      default: w_exp = 64'sd0;
    endcase
    w_mis = (instruction_word.opc > MOD) | (!w_skip & (instruction_word.result !== w_exp));
  end
  // mismatch flag and saturating error counter, cleared by each accepted start
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_mis <= 1'b0;
      r_err <= '0;
    end else if (w_go) begin
      r_err <= '0;
    end else if (r_state == FETCH) begin
      r_mis <= w_mis;
      if (w_mis && r_err != 6'd63) r_err <= r_err + 6'd1;
    end
  assign mismatch = out_valid & r_mis;
  assign err_count = r_err;
`else
  assign mismatch = 1'b0;
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_instr_reader.sv
// tb_instr_reader: directed self-checking bench for instr_reader
module tb_instr_reader;
  import instr_register_pkg::*;
`ifdef INSTR_READER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 0, reset_n = 0, start = 0, out_ready = 0;
  address_t start_ptr = '0, read_pointer, out_index;
  logic [5:0] count = '0, err_count;
  instruction_t instruction_word, out_instr;
  logic out_valid, mismatch, busy, done;
  instruction_t mem [32];
  int n_checks = 0, n_errors = 0;
  int n_xfer, n_done, first_done;
  logic [4:0] idx_a [8];
  logic [63:0] res_a [8];
  logic mis_a [8];

  assign instruction_word = mem[read_pointer];
  always #5 clk = ~clk;

  instr_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_ptr(start_ptr), .count(count),
    .instruction_word(instruction_word), .read_pointer(read_pointer), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_index(out_index), .mismatch(mismatch),
    .busy(busy), .done(done), .err_count(err_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic instruction_t mk(input opcode_t o, input int a, input int b, input longint r);
    instruction_t t;
    t.opc = o; t.op_a = a; t.op_b = b; t.result = r;
    return t;
  endfunction

  task automatic start_run(input logic [4:0] p, input logic [5:0] c);
    start = 1; start_ptr = p; count = c;
    @(negedge clk);
    start = 0;
  endtask

  task automatic collect(input int max_cyc);
    int c;
    n_xfer = 0; n_done = 0; first_done = -1;
    for (c = 0; c < max_cyc; c++) begin
      if (out_valid && out_ready) begin
        if (n_xfer < 8) begin
          idx_a[n_xfer] = out_index;
          res_a[n_xfer] = out_instr.result;
          mis_a[n_xfer] = mismatch;
        end
        n_xfer++;
      end
      if (done) begin
        if (n_done == 0) first_done = c;
        n_done++;
      end
      if (n_done != 0 && !busy) break;
      @(negedge clk);
    end
    if (c == max_cyc) check("run_timeout", n_done, 1);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;
    // reset state
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rp", read_pointer, 0);
    check("rst_idx", out_index, 0);
    check("rst_err", err_count, 0);
    check("rst_instr_res", out_instr.result, 0);
    reset_n = 1;
    @(negedge clk);
    // single ADD word, step by step
    mem[3] = mk(ADD, 5, -7, -2);
    out_ready = 1;
    start_run(3, 1);
    check("t1_fetch_valid", out_valid, 0);
    check("t1_fetch_rp", read_pointer, 3);
    check("t1_fetch_busy", busy, 1);
    @(negedge clk);
    check("t1_valid", out_valid, 1);
    check("t1_idx", out_index, 3);
    check("t1_res", out_instr.result, -64'sd2);
    check("t1_mis", mismatch, 0);
    @(negedge clk);
    check("t1_done", done, 1);
    check("t1_valid_fall", out_valid, 0);
    @(negedge clk);
    check("t1_done_fall", done, 0);
    check("t1_idle", busy, 0);
    check("t1_err", err_count, 0);
    // wrapping MULT run
    for (int i = 0; i < 4; i++) mem[(30 + i) % 32] = mk(MULT, 100000, 100000, 64'd10000000000);
    start_run(30, 4);
    collect(40);
    check("t2_xfers", n_xfer, 4);
    check("t2_dones", n_done, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_idx%0d", i), idx_a[i], (30 + i) % 32);
      check($sformatf("t2_res%0d", i), res_a[i], 64'd10000000000);
    end
    check("t2_err", err_count, 0);
    // backpressure hold
    mem[5] = mk(PASSA, 11, 22, 11);
    out_ready = 0;
    start_run(5, 1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("t3_valid", out_valid, 1);
      check("t3_instr", out_instr, mk(PASSA, 11, 22, 11));
      check("t3_rp", read_pointer, 5);
      @(negedge clk);
    end
    out_ready = 1;
    check("t3_valid_pre", out_valid, 1);
    @(negedge clk);
    check("t3_done", done, 1);
    check("t3_valid_after", out_valid, 0);
    @(negedge clk);
    // divide by zero skip and corrupted SUB
    mem[7] = mk(DIV, 9, 0, 123);
    mem[8] = mk(SUB, 4, 1, 0);
    start_run(7, 2);
    collect(40);
    check("t4_xfers", n_xfer, 2);
    check("t4_idx0", idx_a[0], 7);
    check("t4_mis7", mis_a[0], 0);
    check("t4_idx1", idx_a[1], 8);
    check("t4_mis8", mis_a[1], CHK);
    check("t4_err", err_count, CHK ? 6'd1 : 6'd0);
    // err_count cleared by next start
    mem[9] = mk(MOD, -7, 2, -1);
    mem[10] = mk(DIV, -7, 2, -3);
    start_run(9, 2);
    collect(40);
    check("t4b_mis_mod", mis_a[0], 0);
    check("t4b_mis_div", mis_a[1], 0);
    check("t4b_err", err_count, 0);
    // bad opcode
    mem[12] = mk(opcode_t'(4'd12), 0, 0, 0);
    start_run(12, 1);
    collect(40);
    check("t4c_badop", mis_a[0], CHK);
    // count zero
    start_run(20, 0);
    collect(10);
    check("t5_zero_xfers", n_xfer, 0);
    check("t5_zero_dones", n_done, 1);
    check("t5_zero_win", first_done <= 1, 1);
    // start while busy is ignored
    for (int i = 10; i < 13; i++) mem[i] = mk(PASSB, 1, i, i);
    start_run(10, 3);
    start = 1; start_ptr = 20; count = 5;
    @(negedge clk);
    start = 0;
    collect(40);
    check("t5_busy_xfers", n_xfer, 3);
    check("t5_busy_dones", n_done, 1);
    for (int i = 0; i < 3; i++) check($sformatf("t5_idx%0d", i), idx_a[i], 10 + i);
    // clamp of oversized count
    start_run(0, 6'd40);
    collect(200);
    check("t5_clamp", n_xfer, 32);
    // asynchronous reset mid-run
    mem[14] = mk(PASSA, 3, 4, 3);
    mem[15] = mk(PASSB, 3, 4, 4);
    out_ready = 0;
    start_run(14, 2);
    @(negedge clk);
    check("t6_pre_valid", out_valid, 1);
    #2 reset_n = 0;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_rp", read_pointer, 0);
    check("t6_idx", out_index, 0);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    check("t6_idle", busy, 0);
    out_ready = 1;
    start_run(14, 2);
    collect(40);
    check("t6_xfers", n_xfer, 2);
    check("t6_idx0", idx_a[0], 14);
    check("t6_idx1", idx_a[1], 15);
    check("t6_res1", res_a[1], 4);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
